mc_cu: RTL and testbench
========================

Name: mc_cu

Overview:
- Multi-cycle successor to the single-cycle control unit for the same MIPS subset.
- Instruction classes: add/sub/and/or/xor/sll/srl/sra/jr, addi/andi/ori/xori/lw/sw/beq/bne/lui, j/jal.
- A state machine (IF, ID, EXE, MEM, WB) drives a shared-ALU datapath with IR, A/B and ALUout registers.
- Adds what the single-cycle unit lacks: a memory ready handshake, a bounded wait timeout, and illegal-opcode trapping to an error state.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles with mem_req high and mem_ready low before a timeout trap. 0 means wait forever.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clock  in  1: system clock, rising edge.
- resetn  in  1: asynchronous reset, active-low.
- op  in  6: IR[31:26].
- func  in  6: IR[5:0].
- z  in  1: ALU zero flag, valid in EXE.
- mem_ready  in  1: memory completes the current request this cycle.
- mem_req  out  1: memory access request.
- iord  out  1: address select. 0 = PC, 1 = ALUout.
- wmem  out  1: write strobe, qualified by mem_req.
- wir  out  1: IR load enable.
- wpc  out  1: PC load enable.
- pcsource  out  2: 00 = ALU result, 01 = ALUout (branch target), 10 = reg A (jr), 11 = jump address.
- alua_sel  out  2: 00 = reg A, 01 = PC, 10 = sa field.
- alub_sel  out  2: 00 = reg B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- aluc  out  4: same encoding as the single-cycle unit (add x000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111).
- sext  out  1: sign-extend the immediate.
- wreg  out  1: register file write enable.
- regrt  out  1: destination register = rt.
- m2reg  out  1: write-back data from the memory data register.
- jal  out  1: destination r31, data PC (already PC+4).
- err  out  1: trapped.
- cause  out  2: 00 none, 01 illegal instruction, 10 memory timeout.
- state  out  3: current state, for debug.

Behaviour:
- Reset:
  - Asynchronous on resetn low: state = IF, wait counter = 0, cause = 00.
  - While resetn is low, all enables (mem_req, wmem, wir, wpc, wreg) are forced to 0.
  - Reset mid-access abandons the access with no write.
- Outputs are decoded from state plus the decoded instruction. Any enable not listed for a state is 0.
- IF:
  - mem_req = 1, iord = 0, alua = PC, alub = 4, aluc = add, pcsource = 00.
  - wir = wpc = mem_ready.
  - mem_ready -> ID. Otherwise stay in IF.
- ID:
  - alua = PC, alub = imm << 2, sext = 1, aluc = add; ALUout captures the branch target.
  - j -> wpc = 1, pcsource = 11, next IF.
  - jal -> wpc = 1, pcsource = 11, wreg = 1, jal = 1, next IF.
  - jr -> wpc = 1, pcsource = 10, next IF.
  - Illegal op/func (including r_type with an unlisted func) -> ERR, cause = 01, no enables.
  - All other instructions -> EXE.
- EXE:
  - beq/bne: alua = A, alub = B, aluc = sub. wpc = (beq & z) | (bne & ~z), pcsource = 01. Next IF.
  - lw/sw: alub = imm, sext = 1, aluc = add. Next MEM.
  - Shifts: alua = sa, alub = B.
  - Other R-type: alua = A, alub = B.
  - I-type ALU: alub = imm; sext = 1 for addi only, zero-extend for andi/ori/xori/lui.
  - Shifts, other R-type and I-type ALU all go to WB next.
- MEM:
  - mem_req = 1, iord = 1, wmem = sw.
  - Waits for mem_ready. Then lw -> WB, sw -> IF.
- WB:
  - wreg = 1, regrt = I-type, m2reg = lw.
  - Next IF.
- ERR: terminal; err = 1, every enable 0, cause held until reset.
- Wait counter:
  - Increments each cycle with mem_req = 1 and mem_ready = 0.
  - Clears on mem_ready or on leaving IF/MEM.
  - If WAIT_LIMIT != 0 and the counter equals WAIT_LIMIT with mem_ready still 0 -> ERR, cause = 10.
  - mem_ready arriving in the same cycle the limit is reached wins: the access completes and there is no trap.
  - The counter saturates and never wraps.
- Latency with zero-wait memory (mem_ready always 1):
  - j/jal/jr: 2 cycles.
  - branch: 3 cycles.
  - ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.

Decomposition:
- Package mc_cu_pkg holds:
  - state encoding (IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4, ERR = 7);
  - aluc codes;
  - pcsource, alua_sel and alub_sel codes;
  - cause codes;
  - opcode and func constants.
- Sub-module mc_cu_decode is purely combinational: op/func -> one-hot instruction class, aluc, immediate kind, illegal.
- The top level holds only the FSM, the wait counter and output muxing.

Test Plan:
- addi (op 001000), mem_ready tied 1 -> states IF, ID, EXE, WB, IF. wreg = 1 only in WB, with regrt = 1 and sext = 1 in EXE.
- lw with mem_ready low for 3 cycles in MEM -> MEM lasts 4 cycles, then WB with m2reg = 1. Total 8 cycles; err stays 0.
- beq with z = 1, then bne with z = 1 -> wpc = 1 with pcsource = 01 for beq. wpc = 0 for bne in EXE.
- jal (op 000011) -> 2 cycles. In ID: wpc = 1, pcsource = 11, wreg = 1, jal = 1.
- r_type with func 111111 -> ERR after ID, cause = 01. All enables stay 0 for 20 cycles. resetn pulse -> IF, err = 0.
- WAIT_LIMIT = 15, mem_ready held 0 in IF -> trap after 15 wait cycles, cause = 10. Repeat with mem_ready asserted on exactly that cycle -> no trap, wir = 1.

Source files
------------

// File: rtl/mc_cu_pkg.sv
// mc_cu_pkg: shared encodings for the multi-cycle MIPS-subset control unit.
// Holds state, ALU, mux-select and cause codes, opcodes/funcs, class struct.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_REGA   = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] A_REG = 2'b00;
    localparam logic [1:0] A_PC  = 2'b01;
    localparam logic [1:0] A_SA  = 2'b10;

    localparam logic [1:0] B_REG  = 2'b00;
    localparam logic [1:0] B_FOUR = 2'b01;
    localparam logic [1:0] B_IMM  = 2'b10;
    localparam logic [1:0] B_IMM2 = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_TMO  = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    // One-hot instruction class; all-zero means illegal.
    typedef struct packed {
        logic r_alu;
        logic shift;
        logic jr;
        logic i_alu;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
    } icls_t;

endpackage

// File: rtl/mc_cu_if.sv
// mc_cu_if: memory request/ready handshake between control unit and memory.
// master: mem_req/iord/wmem out, mem_ready in. slave: the reverse.
interface mc_cu_if;
    logic mem_req;
    logic iord;
    logic wmem;
    logic mem_ready;

    modport master (output mem_req, output iord, output wmem,
                    input mem_ready);
    modport slave (input mem_req, input iord, input wmem,
                   output mem_ready);
endinterface

// File: rtl/mc_cu_decode.sv
// mc_cu_decode: combinational op/func -> one-hot class, aluc, imm kind.
// Ports: op, func in; cls, aluc, imm_sext, illegal out.
module mc_cu_decode
    import mc_cu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output icls_t      cls,
    output logic [3:0] aluc,
    output logic       imm_sext,
    output logic       illegal
);

    always_comb begin
        cls      = '0;
        aluc     = ALU_ADD;
        imm_sext = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD: begin cls.r_alu = 1'b1; aluc = ALU_ADD; end
                    FN_SUB: begin cls.r_alu = 1'b1; aluc = ALU_SUB; end
                    FN_AND: begin cls.r_alu = 1'b1; aluc = ALU_AND; end
                    FN_OR:  begin cls.r_alu = 1'b1; aluc = ALU_OR;  end
                    FN_XOR: begin cls.r_alu = 1'b1; aluc = ALU_XOR; end
                    FN_SLL: begin cls.shift = 1'b1; aluc = ALU_SLL; end
                    FN_SRL: begin cls.shift = 1'b1; aluc = ALU_SRL; end
                    FN_SRA: begin cls.shift = 1'b1; aluc = ALU_SRA; end
                    FN_JR:  cls.jr = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI: begin
                cls.i_alu = 1'b1; aluc = ALU_ADD; imm_sext = 1'b1;
            end
            OP_ANDI: begin cls.i_alu = 1'b1; aluc = ALU_AND; end
            OP_ORI:  begin cls.i_alu = 1'b1; aluc = ALU_OR;  end
            OP_XORI: begin cls.i_alu = 1'b1; aluc = ALU_XOR; end
            OP_LUI:  begin cls.i_alu = 1'b1; aluc = ALU_LUI; end
            OP_LW:   begin cls.lw = 1'b1; imm_sext = 1'b1; end
            OP_SW:   begin cls.sw = 1'b1; imm_sext = 1'b1; end
            OP_BEQ: begin
                cls.beq = 1'b1; aluc = ALU_SUB; imm_sext = 1'b1;
            end
            OP_BNE: begin
                cls.bne = 1'b1; aluc = ALU_SUB; imm_sext = 1'b1;
            end
            OP_J:   cls.j = 1'b1;
            OP_JAL: cls.jal = 1'b1;
            default: ;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit FSM (IF/ID/EXE/MEM/WB/ERR) with memory
// wait timeout and illegal-op trap. Ports: clock, resetn, op, func, z,
// mem (handshake), datapath controls, err/cause/state status.
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    mc_cu_if.master    mem,
    output logic       wir,
    output logic       wpc,
    output logic [1:0] pcsource,
    output logic [1:0] alua_sel,
    output logic [1:0] alub_sel,
    output logic [3:0] aluc,
    output logic       sext,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       err,
    output logic [1:0] cause,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit               TMO_EN  = (WAIT_LIMIT != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;

    icls_t      cls;
    logic [3:0] dec_aluc;
    logic       imm_sext;
    logic       illegal;

    logic req_c, iord_c, wmem_c, wir_c, wpc_c, wreg_c;
    logic tmo;
    logic [CNT_W-1:0] cnt_inc;

    mc_cu_decode u_dec (
        .op       (op),
        .func     (func),
        .cls      (cls),
        .aluc     (dec_aluc),
        .imm_sext (imm_sext),
        .illegal  (illegal)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Trap only when the limit is reached and memory is still not ready;
    // a same-cycle mem_ready is checked first and wins.
    assign tmo     = TMO_EN && (cnt_q == LIMIT);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cnt_d    = '0;
        req_c    = 1'b0;
        iord_c   = 1'b0;
        wmem_c   = 1'b0;
        wir_c    = 1'b0;
        wpc_c    = 1'b0;
        wreg_c   = 1'b0;
        pcsource = PC_ALU;
        alua_sel = A_REG;
        alub_sel = B_REG;
        aluc     = ALU_ADD;
        sext     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            S_IF: begin
                req_c    = 1'b1;
                alua_sel = A_PC;
                alub_sel = B_FOUR;
                wir_c    = mem.mem_ready;
                wpc_c    = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_d = S_ID;
                end else if (tmo) begin
                    state_d = S_ERR;
                    cause_d = CAUSE_TMO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ID: begin
                alua_sel = A_PC;
                alub_sel = B_IMM2;
                sext     = 1'b1;
                if (illegal) begin
                    state_d = S_ERR;
                    cause_d = CAUSE_ILL;
                end else if (cls.j) begin
                    wpc_c    = 1'b1;
                    pcsource = PC_JUMP;
                    state_d  = S_IF;
                end else if (cls.jal) begin
                    wpc_c    = 1'b1;
                    pcsource = PC_JUMP;
                    wreg_c   = 1'b1;
                    jal      = 1'b1;
                    state_d  = S_IF;
                end else if (cls.jr) begin
                    wpc_c    = 1'b1;
                    pcsource = PC_REGA;
                    state_d  = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (cls.beq || cls.bne) begin
                    aluc     = ALU_SUB;
                    pcsource = PC_ALUOUT;
                    wpc_c    = (cls.beq & z) | (cls.bne & ~z);
                    state_d  = S_IF;
                end else if (cls.lw || cls.sw) begin
                    alub_sel = B_IMM;
                    sext     = 1'b1;
                    state_d  = S_MEM;
                end else if (cls.shift) begin
                    alua_sel = A_SA;
                    aluc     = dec_aluc;
                    state_d  = S_WB;
                end else if (cls.r_alu) begin
                    aluc    = dec_aluc;
                    state_d = S_WB;
                end else begin
                    alub_sel = B_IMM;
                    sext     = imm_sext;
                    aluc     = dec_aluc;
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                req_c  = 1'b1;
                iord_c = 1'b1;
                wmem_c = cls.sw;
                if (mem.mem_ready) begin
                    state_d = cls.lw ? S_WB : S_IF;
                end else if (tmo) begin
                    state_d = S_ERR;
                    cause_d = CAUSE_TMO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                wreg_c  = 1'b1;
                regrt   = cls.i_alu | cls.lw;
                m2reg   = cls.lw;
                state_d = S_IF;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // Enables are held off while reset is asserted, even though the
    // state register already reads IF.
    assign mem.mem_req = req_c & resetn;
    assign mem.iord    = iord_c;
    assign mem.wmem    = wmem_c & resetn;
    assign wir         = wir_c & resetn;
    assign wpc         = wpc_c & resetn;
    assign wreg        = wreg_c & resetn;
    assign cause       = cause_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: directed self-checking bench for mc_cu.
// Drives op/func/z/mem_ready, checks controls per state with assertions.
module tb_mc_cu;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;
    logic       z = 1'b0;
    logic       wir, wpc, sext, wreg, regrt, m2reg, jal, err;
    logic [1:0] pcsource, alua_sel, alub_sel, cause;
    logic [3:0] aluc;
    logic [2:0] state;

    int vecs = 0;
    int errs = 0;

    mc_cu_if bus ();

    mc_cu #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .op       (op),
        .func     (func),
        .z        (z),
        .mem      (bus),
        .wir      (wir),
        .wpc      (wpc),
        .pcsource (pcsource),
        .alua_sel (alua_sel),
        .alub_sel (alub_sel),
        .aluc     (aluc),
        .sext     (sext),
        .wreg     (wreg),
        .regrt    (regrt),
        .m2reg    (m2reg),
        .jal      (jal),
        .err      (err),
        .cause    (cause),
        .state    (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] enables;
        return {bus.mem_req, bus.wmem, wir, wpc, wreg};
    endfunction

    initial begin
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_enables", enables(), 0);
        chk("rst_cause", cause, 0);
        chk("rst_err", err, 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        #1;

        // addi: IF ID EXE WB IF
        op = 6'b001000;
        #1;
        chk("addi_if_state", state, 0);
        chk("addi_if_req", {bus.mem_req, bus.iord, wir, wpc}, 4'b1011);
        chk("addi_if_alu", {alua_sel, alub_sel, aluc}, 8'b01_01_0000);
        chk("addi_if_wreg", wreg, 0);
        step;
        chk("addi_id_state", state, 1);
        chk("addi_id_sel", {alua_sel, alub_sel, sext}, 5'b01_11_1);
        chk("addi_id_wreg", wreg, 0);
        step;
        chk("addi_exe_state", state, 2);
        chk("addi_exe_ctl", {alub_sel, sext, aluc}, 7'b10_1_0000);
        chk("addi_exe_wreg", wreg, 0);
        step;
        chk("addi_wb_state", state, 4);
        chk("addi_wb_ctl", {wreg, regrt, m2reg}, 3'b110);
        step;
        chk("addi_back_if", state, 0);

        // ori: zero-extended immediate
        op = 6'b001101;
        step;
        step;
        chk("ori_exe_ctl", {alub_sel, sext, aluc}, 7'b10_0_0101);
        step;
        step;

        // sll: shift amount on port A
        op = 6'b000000;
        func = 6'b000000;
        step;
        step;
        chk("sll_exe_ctl", {alua_sel, alub_sel, aluc}, 8'b10_00_0011);
        step;
        chk("sll_wb_regrt", {wreg, regrt}, 2'b10);
        step;

        // lw with 3 wait cycles in MEM
        op = 6'b100011;
        #1;
        chk("lw_if_state", state, 0);
        step;
        step;
        chk("lw_exe_sel", {alub_sel, sext}, 3'b10_1);
        step;
        bus.mem_ready = 1'b0;
        #1;
        chk("lw_mem1_state", state, 3);
        chk("lw_mem1_ctl", {bus.mem_req, bus.iord, bus.wmem}, 3'b110);
        step;
        chk("lw_mem2_state", state, 3);
        step;
        chk("lw_mem3_state", state, 3);
        step;
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_mem4_state", state, 3);
        step;
        chk("lw_wb_state", state, 4);
        chk("lw_wb_ctl", {wreg, regrt, m2reg}, 3'b111);
        chk("lw_err", err, 0);
        step;
        chk("lw_back_if", state, 0);

        // sw: write strobe in MEM, then IF
        op = 6'b101011;
        step;
        step;
        step;
        chk("sw_mem_ctl", {bus.mem_req, bus.iord, bus.wmem}, 3'b111);
        step;
        chk("sw_back_if", state, 0);

        // beq z=1 taken, bne z=1 not taken
        op = 6'b000100;
        z = 1'b1;
        step;
        step;
        chk("beq_exe_state", state, 2);
        chk("beq_exe_ctl", {wpc, pcsource, aluc}, 7'b1_01_0100);
        step;
        chk("beq_back_if", state, 0);
        op = 6'b000101;
        step;
        step;
        chk("bne_exe_wpc", wpc, 0);
        step;
        chk("bne_back_if", state, 0);

        // jal: 2 cycles
        op = 6'b000011;
        z = 1'b0;
        step;
        chk("jal_id_ctl", {wpc, pcsource, wreg, jal}, 5'b1_11_1_1);
        step;
        chk("jal_back_if", state, 0);

        // jr
        op = 6'b000000;
        func = 6'b001000;
        step;
        chk("jr_id_ctl", {wpc, pcsource, wreg}, 4'b1_10_0);
        step;
        chk("jr_back_if", state, 0);

        // illegal R-type func
        func = 6'b111111;
        step;
        chk("ill_id_en", enables(), 0);
        step;
        chk("ill_state", state, 7);
        chk("ill_err_cause", {err, cause}, 3'b1_01);
        for (int i = 0; i < 20; i++) begin
            step;
            chk("ill_hold", {enables(), state, cause}, 10'b00000_111_01);
        end
        resetn = 1'b0;
        #1;
        chk("ill_rst_state", state, 0);
        chk("ill_rst_en", enables(), 0);
        bus.mem_ready = 1'b0;
        #1 resetn = 1'b1;
        #1;
        chk("ill_rst_err", {err, cause}, 3'b0_00);

        // timeout: 15 wait cycles tolerated, trap on the next
        repeat (15) step;
        chk("tmo_still_if", {state, err}, 4'b000_0);
        step;
        chk("tmo_state", state, 7);
        chk("tmo_cause", {err, cause}, 3'b1_10);

        // same with mem_ready on the limit cycle
        resetn = 1'b0;
        #1 resetn = 1'b1;
        op = 6'b001000;
        func = 6'b000000;
        repeat (15) step;
        bus.mem_ready = 1'b1;
        #1;
        chk("lim_ready_wir", {wir, wpc, err}, 3'b110);
        step;
        chk("lim_ready_id", {state, cause}, 5'b001_00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
